aileron_valve_sequencer: RTL and testbench

Sequenced, parametrised aileron valve driver: takes a signed angle command and drives N thermometer-coded valves per side (left for negative, right for positive). Valve changes are rate-limited to one level per STEP_CYCLES. On a direction reversal, all valves on the old side close, then a dead-time elapses before the opposite side opens. It sits between the flight-control angle source and the valve solenoid drivers. It is the clocked successor of the combinational 4-bit, 2-valve aileron actuator.

---
 rtl/aileron_valve_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_aileron_valve_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aileron_valve_sequencer.sv
// Rate-limited aileron valve driver: signed angle command in, thermometer-coded
// left/right valve banks out, with a dead time whenever the active side reverses.
module aileron_valve_sequencer #(
    parameter int ANG_W       = 4,
    parameter int N_VALVES    = 2,
    parameter int STEP_CYCLES = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ANG_W-1:0]    cmd_ang,
    output logic [N_VALVES-1:0] valve_l,
    output logic [N_VALVES-1:0] valve_r,
    output logic                busy,
    output logic                settled
);
    localparam int LVL_W = $clog2(N_VALVES + 1);
    localparam int MAG_W = ANG_W - 1;
    localparam int RAW_W = MAG_W + 1;
    localparam int SHIFT = ANG_W - 1 - $clog2(N_VALVES);
    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int DED_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
    localparam logic [DED_W-1:0] DED_LAST = DED_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        SIDE_NONE  = 2'd0,
        SIDE_LEFT  = 2'd1,
        SIDE_RIGHT = 2'd2
    } side_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    side_t             side_reg, side_next;
    side_t             tgt_side_reg, tgt_side_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [LVL_W-1:0]  tgt_level_reg, tgt_level_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic [DED_W-1:0]  dead_reg, dead_next;

    logic              accept;
    logic [MAG_W-1:0]  cmd_mag;
    logic [RAW_W-1:0]  cmd_lvl_raw;
    logic [LVL_W-1:0]  cmd_level;
    side_t             cmd_side;
    side_t             eff_side;
    logic [LVL_W-1:0]  eff_level;
    logic              at_target;
    logic              toward;

    // Command decode: magnitude with most-negative saturation, then level bucket.
    always_comb begin
        if (!cmd_ang[ANG_W-1]) begin
            cmd_mag = cmd_ang[MAG_W-1:0];
        end else if (cmd_ang[MAG_W-1:0] == '0) begin
            cmd_mag = '1;
        end else begin
            cmd_mag = ~cmd_ang[MAG_W-1:0] + MAG_W'(1);
        end

        cmd_lvl_raw = ({1'b0, cmd_mag} >> SHIFT) + RAW_W'(1);

        if (cmd_ang == '0) begin
            cmd_level = '0;
            cmd_side  = SIDE_NONE;
        end else begin
            cmd_level = (cmd_lvl_raw > RAW_W'(N_VALVES)) ? LVL_W'(N_VALVES)
                                                         : LVL_W'(cmd_lvl_raw);
            cmd_side  = cmd_ang[ANG_W-1] ? SIDE_LEFT : SIDE_RIGHT;
        end
    end

    assign cmd_ready = (state_reg != DEAD);
    assign settled   = (state_reg == IDLE);
    assign busy      = ~settled;
    assign accept    = cmd_valid & cmd_ready;

    // A command accepted this edge takes effect in this edge's decision.
    assign eff_side  = accept ? cmd_side  : tgt_side_reg;
    assign eff_level = accept ? cmd_level : tgt_level_reg;
    assign at_target = (level_reg == eff_level) &&
                       ((level_reg == '0) || (side_reg == eff_side));
    assign toward    = (level_reg == '0) || (side_reg == eff_side);

    always_comb begin
        state_next     = state_reg;
        side_next      = side_reg;
        level_next     = level_reg;
        tgt_side_next  = eff_side;
        tgt_level_next = eff_level;
        timer_next     = '0;
        dead_next      = '0;

        case (state_reg)
            IDLE: begin
                if (!at_target) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                if (at_target) begin
                    state_next = IDLE;
                    if (level_reg == '0) begin
                        side_next = SIDE_NONE;
                    end
                end else if (timer_reg != TMR_LAST) begin
                    timer_next = timer_reg + 1'b1;
                end else if (toward) begin
                    side_next  = eff_side;
                    level_next = (level_reg < eff_level) ? level_reg + 1'b1
                                                         : level_reg - 1'b1;
                    if (level_next == eff_level) begin
                        state_next = IDLE;
                    end
                end else begin
                    // Wrong side: close down first, dead time only if reopening.
                    level_next = level_reg - 1'b1;
                    if (level_next == '0) begin
                        side_next  = SIDE_NONE;
                        state_next = (eff_level == '0) ? IDLE : DEAD;
                    end
                end
            end
            DEAD: begin
                if (dead_reg == DED_LAST) begin
                    state_next = STEP;
                    side_next  = eff_side;
                    level_next = '0;
                end else begin
                    dead_next = dead_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                side_next  = SIDE_NONE;
                level_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            side_reg      <= SIDE_NONE;
            level_reg     <= '0;
            tgt_side_reg  <= SIDE_NONE;
            tgt_level_reg <= '0;
            timer_reg     <= '0;
            dead_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            side_reg      <= side_next;
            level_reg     <= level_next;
            tgt_side_reg  <= tgt_side_next;
            tgt_level_reg <= tgt_level_next;
            timer_reg     <= timer_next;
            dead_reg      <= dead_next;
        end
    end

    // Outputs decode registered state only; a single side register keeps banks exclusive.
    logic [N_VALVES-1:0] therm;

    generate
        for (genvar gi = 0; gi < N_VALVES; gi++) begin : g_therm
            assign therm[gi] = (level_reg > LVL_W'(gi));
        end
    endgenerate

    assign valve_l = (side_reg == SIDE_LEFT)  ? therm : '0;
    assign valve_r = (side_reg == SIDE_RIGHT) ? therm : '0;

endmodule

// File: tb/tb_aileron_valve_sequencer.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor
// pops one per observed output change and checks values and cycle of arrival.
module tb_aileron_valve_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       c1_valid = 1'b0;
    logic [3:0] c1_ang = '0;
    logic       c1_ready, c1_busy, c1_settled;
    logic [1:0] vl1, vr1;

    logic       c2_valid = 1'b0;
    logic [5:0] c2_ang = '0;
    logic       c2_ready, c2_busy, c2_settled;
    logic [3:0] vl2, vr2;

    aileron_valve_sequencer dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (c1_valid),
        .cmd_ready (c1_ready),
        .cmd_ang   (c1_ang),
        .valve_l   (vl1),
        .valve_r   (vr1),
        .busy      (c1_busy),
        .settled   (c1_settled)
    );

    aileron_valve_sequencer #(
        .ANG_W(6), .N_VALVES(4), .STEP_CYCLES(1), .DEAD_CYCLES(2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (c2_valid),
        .cmd_ready (c2_ready),
        .cmd_ang   (c2_ang),
        .valve_l   (vl2),
        .valve_r   (vr2),
        .busy      (c2_busy),
        .settled   (c2_settled)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] vl;
        logic [3:0] vr;
        logic       rdy;
        logic       stl;
    } ev_t;

    ev_t  q1[$];
    ev_t  q2[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic [9:0] prev1 = 10'b0000000011;
    logic [9:0] prev2 = 10'b0000000011;

    task automatic exp1(input int c, input int l, input int r, input int rdy, input int stl);
        ev_t e;
        e.cyc = c; e.vl = 4'(l); e.vr = 4'(r); e.rdy = 1'(rdy); e.stl = 1'(stl);
        q1.push_back(e);
    endtask

    task automatic exp2(input int c, input int l, input int r, input int rdy, input int stl);
        ev_t e;
        e.cyc = c; e.vl = 4'(l); e.vr = 4'(r); e.rdy = 1'(rdy); e.stl = 1'(stl);
        q2.push_back(e);
    endtask

    task automatic check_ev(input int id, input logic [9:0] o);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (id == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        total++;
        if (!have) begin
            bad++;
            $display("FAIL dut%0d unexpected_change: cyc=%0d vl=%b vr=%b rdy=%b stl=%b, required no change",
                     id, cyc, o[9:6], o[5:2], o[1], o[0]);
        end else if (o != {e.vl, e.vr, e.rdy, e.stl} || cyc != e.cyc) begin
            bad++;
            $display("FAIL dut%0d event: got cyc=%0d vl=%b vr=%b rdy=%b stl=%b, required cyc=%0d vl=%b vr=%b rdy=%b stl=%b",
                     id, cyc, o[9:6], o[5:2], o[1], o[0], e.cyc, e.vl, e.vr, e.rdy, e.stl);
        end else begin
            $display("ok   dut%0d cyc=%0d vl=%b vr=%b rdy=%b stl=%b", id, cyc, e.vl, e.vr, e.rdy, e.stl);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [9:0] o1, o2;
        o1 = {2'b00, vl1, 2'b00, vr1, c1_ready, c1_settled};
        o2 = {vl2, vr2, c2_ready, c2_settled};
        if (mon_en) begin
            total++;
            if ((vl1 != '0 && vr1 != '0) || (vl2 != '0 && vr2 != '0)) begin
                bad++;
                $display("FAIL both_sides: cyc=%0d vl1=%b vr1=%b vl2=%b vr2=%b, required one side zero",
                         cyc, vl1, vr1, vl2, vr2);
            end
            if (o1 != prev1) check_ev(1, o1);
            if (o2 != prev2) check_ev(2, o2);
        end
        prev1 = o1;
        prev2 = o2;
    end

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic send1(input logic [3:0] a, output int e0);
        @(negedge clk); #1;
        c1_valid = 1'b1;
        c1_ang   = a;
        @(posedge clk); #1;
        e0 = cyc;
        c1_valid = 1'b0;
    endtask

    task automatic send2(input logic [5:0] a, output int e0);
        @(negedge clk); #1;
        c2_valid = 1'b1;
        c2_ang   = a;
        @(posedge clk); #1;
        e0 = cyc;
        c2_valid = 1'b0;
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (q1.size() > 0 || q2.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: pending events=%0d, required 0", q1.size() + q2.size());
            q1.delete();
            q2.delete();
        end
        repeat (extra) @(posedge clk);
    endtask

    initial begin : stim
        int e0, e1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(c1_ready), 1);
        chk("rst_settled", int'(c1_settled), 1);
        chk("rst_busy", int'(c1_busy), 0);
        chk("rst_valves", int'({vl1, vr1}), 0);
        chk("rst_valves2", int'({vl2, vr2}), 0);
        mon_en = 1'b1;

        // ramp to +5
        send1(4'd5, e0);
        exp1(e0, 0, 0, 1, 0); exp1(e0 + 4, 0, 1, 1, 0); exp1(e0 + 8, 0, 3, 1, 1);
        drain(3);

        // reversal to -3 through dead time
        send1(4'b1101, e0);
        exp1(e0, 0, 3, 1, 0); exp1(e0 + 4, 0, 1, 1, 0); exp1(e0 + 8, 0, 0, 0, 0);
        exp1(e0 + 10, 0, 0, 1, 0); exp1(e0 + 14, 1, 0, 1, 1);
        drain(3);

        // back to zero, no dead time
        send1(4'd0, e0);
        exp1(e0, 1, 0, 1, 0); exp1(e0 + 4, 0, 0, 1, 1);
        drain(3);

        // most-negative saturates to full left
        send1(4'b1000, e0);
        exp1(e0, 0, 0, 1, 0); exp1(e0 + 4, 1, 0, 1, 0); exp1(e0 + 8, 3, 0, 1, 1);
        drain(3);

        send1(4'd0, e0);
        exp1(e0, 3, 0, 1, 0); exp1(e0 + 4, 1, 0, 1, 0); exp1(e0 + 8, 0, 0, 1, 1);
        drain(3);

        // retarget +7 -> +1 right after the first step lands
        send1(4'd7, e0);
        exp1(e0, 0, 0, 1, 0); exp1(e0 + 4, 0, 1, 1, 0);
        repeat (4) @(posedge clk);
        send1(4'd1, e1);
        chk("retarget_edge", e1 - e0, 5);
        exp1(e1, 0, 1, 1, 1);
        drain(20);

        // climb to +5 then async reset mid-cycle
        send1(4'd5, e0);
        exp1(e0, 0, 1, 1, 0); exp1(e0 + 4, 0, 3, 1, 1);
        drain(2);
        @(posedge clk); #3;
        exp1(cyc, 0, 0, 1, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vr", int'(vr1), 0);
        chk("async_rst_vl", int'(vl1), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", int'(c1_ready), 1);
        chk("post_rst_settled", int'(c1_settled), 1);
        drain(3);

        // wide instance: ANG_W=6, 4 valves, one level per cycle
        send2(6'd1, e0);
        exp2(e0, 0, 0, 1, 0); exp2(e0 + 1, 0, 4'b0001, 1, 1);
        drain(3);
        send2(6'd9, e0);
        exp2(e0, 0, 4'b0001, 1, 0); exp2(e0 + 1, 0, 4'b0011, 1, 1);
        drain(3);
        send2(6'd31, e0);
        exp2(e0, 0, 4'b0011, 1, 0); exp2(e0 + 1, 0, 4'b0111, 1, 0);
        exp2(e0 + 2, 0, 4'b1111, 1, 1);
        drain(3);
        send2(6'd7, e0);
        exp2(e0, 0, 4'b1111, 1, 0); exp2(e0 + 1, 0, 4'b0111, 1, 0);
        exp2(e0 + 2, 0, 4'b0011, 1, 0); exp2(e0 + 3, 0, 4'b0001, 1, 1);
        drain(3);
        send2(6'b100000, e0);
        exp2(e0, 0, 4'b0001, 1, 0); exp2(e0 + 1, 0, 0, 0, 0); exp2(e0 + 3, 0, 0, 1, 0);
        exp2(e0 + 4, 4'b0001, 0, 1, 0); exp2(e0 + 5, 4'b0011, 0, 1, 0);
        exp2(e0 + 6, 4'b0111, 0, 1, 0); exp2(e0 + 7, 4'b1111, 0, 1, 1);
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
